// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU operation sequencer:
//   - datapath widths (operand, opcode, result)
//   - opcode encodings understood by the external combinational ALU
//   - sequencer FSM state encoding
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int OPW  = 4;  // operand width
  localparam int OPCW = 3;  // opcode width
  localparam int RESW = 8;  // ALU result width

  localparam logic [OPCW-1:0] OP_ADD  = 3'b000;
  localparam logic [OPCW-1:0] OP_SUB  = 3'b001;
  localparam logic [OPCW-1:0] OP_MUL  = 3'b010;
  localparam logic [OPCW-1:0] OP_AND  = 3'b011;
  localparam logic [OPCW-1:0] OP_OR   = 3'b100;
  localparam logic [OPCW-1:0] OP_NOT  = 3'b101;
  localparam logic [OPCW-1:0] OP_XOR  = 3'b110;
  localparam logic [OPCW-1:0] OP_XNOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a command
    EXEC = 2'd1,  // operands on the ALU, result captured on the next edge
    HOLD = 2'd2   // result presented until the consumer accepts it
  } state_e;

endpackage : alu_seq_pkg

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Accepts one command at a time, drives registered operands/opcode to an
// external combinational ALU, captures its result one cycle later and holds
// it under a valid/ready handshake. Counts completed results modulo 256.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready is high only in IDLE
//   cmd_a, cmd_b, cmd_op command operands and opcode
//   alu_a, alu_b,        registered operands/opcode to the external ALU
//   alu_opcode           (alu_b forced to zero for NOT)
//   alu_rslt             combinational ALU result
//   res_valid/res_ready  result handshake
//   res_data, res_op     captured result and the opcode that produced it
//   op_count             completed-result counter (wraps 255 -> 0)
//   busy                 high whenever the FSM is not IDLE
//   res_zero, res_wide   only with ALU_SEQ_FLAGS_EN: result flags registered
//                        together with res_data
//
// Build option: define ALU_SEQ_FLAGS_EN to add res_zero / res_wide.
// ---------------------------------------------------------------------------
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OPW-1:0]  cmd_a,
  input  logic [OPW-1:0]  cmd_b,
  input  logic [OPCW-1:0] cmd_op,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  output logic [OPCW-1:0] alu_opcode,
  input  logic [RESW-1:0] alu_rslt,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [RESW-1:0] res_data,
  output logic [OPCW-1:0] res_op,
  output logic [7:0]      op_count,
`ifdef ALU_SEQ_FLAGS_EN
  output logic            res_zero,
  output logic            res_wide,
`endif
  output logic            busy
);

  state_e            state_q,      state_d;
  logic [OPW-1:0]    alu_a_q,      alu_a_d;
  logic [OPW-1:0]    alu_b_q,      alu_b_d;
  logic [OPCW-1:0]   alu_opcode_q, alu_opcode_d;
  logic              res_valid_q,  res_valid_d;
  logic [RESW-1:0]   res_data_q,   res_data_d;
  logic [OPCW-1:0]   res_op_q,     res_op_d;
  logic [7:0]        op_count_q,   op_count_d;
`ifdef ALU_SEQ_FLAGS_EN
  logic              res_zero_q,   res_zero_d;
  logic              res_wide_q,   res_wide_d;
`endif

  // Next-state and datapath update.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_opcode_d = alu_opcode_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_op_d     = res_op_q;
    op_count_d   = op_count_q;
`ifdef ALU_SEQ_FLAGS_EN
    res_zero_d   = res_zero_q;
    res_wide_d   = res_wide_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alu_a_d      = cmd_a;
          // NOT is unary; a clean zero on B keeps the ALU input deterministic.
          alu_b_d      = (cmd_op == OP_NOT) ? '0 : cmd_b;
          alu_opcode_d = cmd_op;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = alu_rslt;
        res_op_d    = alu_opcode_q;
        res_valid_d = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
        // Flags derive from the value being captured so they align with res_data.
        res_zero_d  = (alu_rslt == '0);
        res_wide_d  = (alu_rslt[RESW-1:4] != '0);
`endif
        state_d     = HOLD;
      end
      HOLD: begin
        // res_valid is always high in HOLD, so res_ready alone completes it.
        if (res_ready) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: all storage here is control/datapath flops (no memories), and
      // each has a defined reset value; an in-flight result is simply dropped.
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_op_q     <= '0;
      op_count_q   <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      res_zero_q   <= 1'b0;
      res_wide_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_op_q     <= res_op_d;
      op_count_q   <= op_count_d;
`ifdef ALU_SEQ_FLAGS_EN
      res_zero_q   <= res_zero_d;
      res_wide_q   <= res_wide_d;
`endif
    end
  end

  // Ready depends on state only: no combinational path from res_ready.
  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_op     = res_op_q;
  assign op_count   = op_count_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign res_zero   = res_zero_q;
  assign res_wide   = res_wide_q;
`endif

endmodule : alu_op_sequencer
